rs_stim_seq: RTL and testbench
==============================

# rs_stim_seq

Synthesizable stimulus sequencer that sits directly upstream of the RS flip-flop and drives its `s`/`r` inputs through a fixed phase sequence: idle, reset, set, and optionally forbidden. It replaces hand-timed bench stimulus so that the flip-flop can be exercised on the board. It also checks the flip-flop's `q` output at the end of each checkable phase and latches a sticky error flag on any mismatch.

## Interface
- `DWELL`, default 3: clock cycles per phase. Values below 2 are treated as 2. Maximum is 255.
- `CNT_W`, default 8: width of the dwell counter.
- `clk`  in  1: rising-edge clock.
- `rst`  in  1: asynchronous, active-high reset.
- `start`  in  1: request to run one sequence. Sampled only in IDLE.
- `hold_req`  in  1: while high, freezes the dwell counter. Outputs stay stable.
- `q`  in  1: output of the downstream RS flip-flop.
- `s`  out  1: set drive to the flip-flop. Registered.
- `r`  out  1: reset drive to the flip-flop. Registered.
- `busy`  out  1: high during the ZERO, RST, SET and BOTH states.
- `done`  out  1: one-cycle pulse in the DONE state.
- `err`  out  1: sticky `q` mismatch flag.
- `phase`  out  3: current state code.

## Operation
States and their outputs:
- IDLE: `s`=0, `r`=0.
- ZERO: `s`=0, `r`=0.
- RST: `s`=0, `r`=1.
- SET: `s`=1, `r`=0.
- BOTH: `s`=1, `r`=1.
- DONE: `s`=0, `r`=0.

Transitions:
- IDLE to ZERO when `start`=1.
- ZERO to RST to SET to BOTH to DONE. Each transition happens after the dwell count expires.
- DONE to IDLE unconditionally, after one cycle.

Dwell counting:
- The counter clears on phase entry and increments each cycle when `hold_req`=0.
- The phase ends on the cycle where the counter reaches DWELL-1 and `hold_req`=0.

`q` check:
- `q` is sampled on the final cycle of RST (expected 0) and the final cycle of SET (expected 1).
- ZERO and BOTH are not checked.
- A mismatch sets `err`. `err` is cleared only when `start` is accepted or on `rst`.

Boundary behaviour:
- `start` outside IDLE is ignored. This includes `start` in the DONE cycle.
- `hold_req` in IDLE or DONE has no effect.
- `rst` mid-sequence asynchronously forces IDLE, clears the counter, and drives every output to 0, including `err`.

## Timing
- Reset values: `s`=0, `r`=0, `busy`=0, `done`=0, `err`=0, `phase`=0 (IDLE).
- Edge numbering: the edge that accepts `start` is edge 0.
  - ZERO occupies edges 0..DWELL-1.
  - RST occupies edges DWELL..2·DWELL-1.
  - SET occupies edges 2·DWELL..3·DWELL-1.
  - BOTH occupies edges 3·DWELL..4·DWELL-1.
  - `done` goes high after edge 4·DWELL and falls after edge 4·DWELL+1.
- Each cycle with `hold_req`=1 adds exactly one cycle to the current phase.
- `s`, `r`, `busy` and `phase` change only on `clk` edges, and all are registered. `rst` is the only exception.
- The flip-flop updates `q` one edge after `s`/`r` change. DWELL ≥ 2 guarantees that the sampled `q` reflects the current phase.

## Configuration
- `RS_STIM_FORBID_EN` defined:
  - BOTH phase present.
  - SET goes to BOTH, and BOTH goes to DONE.
  - `done` follows edge 4·DWELL.
- `RS_STIM_FORBID_EN` not defined:
  - BOTH is never entered.
  - SET goes directly to DONE.
  - `done` follows edge 3·DWELL.
  - `s` and `r` are never high together.

## Structure
- Package `rs_stim_pkg` holds:
  - the state codes: IDLE=0, ZERO=1, RST=2, SET=3, BOTH=4, DONE=5;
  - the `phase` width constant (3);
  - the minimum-dwell constant (2).
- Sub-module `rs_dwell_cnt` holds the counter.
  - Inputs: `clr`, `en`, `limit`.
  - Output: `expire`, asserted when count = limit-1 and `en`=1.

## Test plan
All scenarios use DWELL=3.
1. Assert `rst`, then release -> `s`=`r`=`busy`=`done`=`err`=0 and `phase`=0, held with no `start`.
2. One-cycle `start` with a correct flip-flop model, macro defined -> `s`/`r` sequence 00×3, 01×3, 10×3, 11×3; `done` after edge 12 for one cycle; `err`=0.
3. `q` stuck at 1 -> `err`=1 after the final RST cycle and held through DONE. The next `start` clears it.
4. `hold_req` high for 4 cycles mid-SET -> SET lasts 7 cycles with `s`=1, `r`=0 stable; `done` after edge 16.
5. `rst` pulsed mid-SET -> outputs 0 immediately and IDLE after release. `start` pulsed during `busy` is ignored.
6. Macro undefined -> sequence 00×3, 01×3, 10×3; `done` after edge 9; `s`&`r` never both 1.

Source files
------------

// File: rtl/rs_stim_pkg.sv
// Shared state codes, phase width and dwell floor for the RS flip-flop stimulus sequencer.
package rs_stim_pkg;

    localparam int PHASE_W   = 3;
    localparam int MIN_DWELL = 2;

    typedef enum logic [PHASE_W-1:0] {
        ST_IDLE = 3'd0,
        ST_ZERO = 3'd1,
        ST_RST  = 3'd2,
        ST_SET  = 3'd3,
        ST_BOTH = 3'd4,
        ST_DONE = 3'd5
    } state_t;

    // {s, r} drive pattern for each state.
    function automatic logic [1:0] sr_drive(input state_t st);
        logic [1:0] sr;
        sr = 2'b00;
        case (st)
            ST_RST:  sr = 2'b01;
            ST_SET:  sr = 2'b10;
            ST_BOTH: sr = 2'b11;
            default: sr = 2'b00;
        endcase
        return sr;
    endfunction

    function automatic logic is_busy(input state_t st);
        return (st == ST_ZERO) || (st == ST_RST) || (st == ST_SET) || (st == ST_BOTH);
    endfunction

endpackage

// File: rtl/rs_dwell_cnt.sv
// Phase dwell counter: clears on demand, counts while enabled, flags the last cycle of a phase.
module rs_dwell_cnt #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic [CNT_W-1:0] limit,
    output logic             expire
);

    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    logic [CNT_W-1:0] count;

    // A frozen (en=0) cycle never expires, so hold stretches the phase by one cycle each.
    assign expire = en && (count == (limit - ONE));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            count <= count + ONE;
        end
    end

endmodule

// File: rtl/rs_stim_seq.sv
// Drives an RS flip-flop through ZERO/RST/SET(/BOTH) phases and checks q at the end of RST and SET.
// Define RS_STIM_FORBID_EN to include the forbidden s=r=1 BOTH phase.
module rs_stim_seq
    import rs_stim_pkg::*;
#(
    parameter int DWELL = 3,
    parameter int CNT_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               hold_req,
    input  logic               q,
    output logic               s,
    output logic               r,
    output logic               busy,
    output logic               done,
    output logic               err,
    output logic [PHASE_W-1:0] phase
);

    localparam int               DWELL_EFF = (DWELL < MIN_DWELL) ? MIN_DWELL : DWELL;
    localparam logic [CNT_W-1:0] LIMIT     = CNT_W'(DWELL_EFF);

    state_t state;
    state_t nxt;
    logic   expire;
    logic   cnt_clr;
    logic   cnt_en;

    // busy mirrors the counting states, so it doubles as the counter gate.
    assign cnt_en  = busy & ~hold_req;
    assign cnt_clr = ~busy | expire;

    rs_dwell_cnt #(
        .CNT_W (CNT_W)
    ) u_dwell (
        .clk    (clk),
        .rst    (rst),
        .clr    (cnt_clr),
        .en     (cnt_en),
        .limit  (LIMIT),
        .expire (expire)
    );

    always_comb begin
        nxt = state;
        case (state)
            ST_IDLE: if (start)  nxt = ST_ZERO;
            ST_ZERO: if (expire) nxt = ST_RST;
            ST_RST:  if (expire) nxt = ST_SET;
            ST_SET: begin
                if (expire) begin
`ifdef RS_STIM_FORBID_EN
                    nxt = ST_BOTH;
`else
                    nxt = ST_DONE;
`endif
                end
            end
            ST_BOTH: if (expire) nxt = ST_DONE;
            ST_DONE: nxt = ST_IDLE;
            default: nxt = ST_IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with the phase register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
            s     <= 1'b0;
            r     <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
            err   <= 1'b0;
        end else begin
            state    <= nxt;
            {s, r}   <= sr_drive(nxt);
            busy     <= is_busy(nxt);
            done     <= (nxt == ST_DONE);
            if (state == ST_IDLE && start) begin
                err <= 1'b0;
            end else if (expire && state == ST_RST && q != 1'b0) begin
                err <= 1'b1;
            end else if (expire && state == ST_SET && q != 1'b1) begin
                err <= 1'b1;
            end
        end
    end

    assign phase = state;

endmodule

// File: tb/tb_rs_stim_seq.sv
// Directed bench for rs_stim_seq with DWELL=3 and a behavioural RS flip-flop on q.
module tb_rs_stim_seq;

    localparam int DW = 3;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       hold_req;
    logic       q;
    logic       s;
    logic       r;
    logic       busy;
    logic       done;
    logic       err;
    logic [2:0] phase;

    logic q_ff;
    logic q_stuck;

    int checks = 0;
    int errors = 0;

    rs_stim_seq #(
        .DWELL (DW),
        .CNT_W (8)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .hold_req (hold_req),
        .q        (q),
        .s        (s),
        .r        (r),
        .busy     (busy),
        .done     (done),
        .err      (err),
        .phase    (phase)
    );

    always #5 clk = ~clk;

    always @(posedge clk or posedge rst) begin
        if (rst)             q_ff <= 1'b0;
        else if (s && !r)    q_ff <= 1'b1;
        else if (r && !s)    q_ff <= 1'b0;
    end
    assign q = q_stuck ? 1'b1 : q_ff;

    initial begin
        #200000;
        $display("FAIL watchdog obs=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    // Expected phase after edge k (edge 0 accepts start), with hold cycles inside SET.
    function automatic int exp_phase(input int k, input int hold_len);
        int b_end;
        int s_end;
        s_end = 3 * DW + hold_len;
`ifdef RS_STIM_FORBID_EN
        b_end = s_end + DW;
`else
        b_end = s_end;
`endif
        if (k < DW)         return 1;
        else if (k < 2*DW)  return 2;
        else if (k < s_end) return 3;
        else if (k < b_end) return 4;
        else if (k == b_end) return 5;
        return 0;
    endfunction

    function automatic int last_edge(input int hold_len);
`ifdef RS_STIM_FORBID_EN
        return 4 * DW + hold_len;
`else
        return 3 * DW + hold_len;
`endif
    endfunction

    task automatic check_state(input string tag, input int ph, input logic exp_err);
        chk({tag, ".phase"}, 8'(phase), 8'(ph));
        chk({tag, ".s"},     8'(s),     8'(ph == 3 || ph == 4));
        chk({tag, ".r"},     8'(r),     8'(ph == 2 || ph == 4));
        chk({tag, ".busy"},  8'(busy),  8'(ph >= 1 && ph <= 4));
        chk({tag, ".done"},  8'(done),  8'(ph == 5));
        chk({tag, ".err"},   8'(err),   8'(exp_err));
`ifndef RS_STIM_FORBID_EN
        chk({tag, ".sr_excl"}, 8'(s & r), 8'd0);
`endif
    endtask

    // One sequence: optional hold window, optional stray start pulses, optional early abort.
    task automatic run(input string tag, input int hold_start, input int hold_len,
                       input logic stuck, input int abort_edge, input int poke_edge);
        int last;
        logic exp_err;
        last = last_edge(hold_len);
        start = 1'b1;
        for (int k = 0; k <= last + 2; k++) begin
            @(posedge clk);
            #1;
            start = 1'b0;
            exp_err = stuck && (k >= 2 * DW);
            check_state($sformatf("%s.e%0d", tag, k), exp_phase(k, hold_len), exp_err);
            hold_req = (k >= hold_start) && (k < hold_start + hold_len);
            if (k == poke_edge) start = 1'b1;
            if (k == abort_edge) break;
        end
        hold_req = 1'b0;
    endtask

    initial begin
        rst      = 1'b1;
        start    = 1'b0;
        hold_req = 1'b0;
        q_stuck  = 1'b0;

        // Reset state, then idle with no start and stray hold_req.
        repeat (2) @(posedge clk);
        #1;
        check_state("rst_asserted", 0, 1'b0);
        rst = 1'b0;
        hold_req = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_state("idle_hold", 0, 1'b0);
        hold_req = 1'b0;

        // Clean sequence; start during DONE must be ignored.
        run("clean", -1, 0, 1'b0, -1, last_edge(0));

        // q stuck high flags err at the end of RST and keeps it through DONE.
        q_stuck = 1'b1;
        run("stuck", -1, 0, 1'b1, -1, -1);
        repeat (2) @(posedge clk);
        #1;
        check_state("stuck_idle", 0, 1'b1);

        // Next start clears err.
        q_stuck = 1'b0;
        run("clear", -1, 0, 1'b0, -1, -1);

        // Four hold cycles in SET stretch it to seven cycles.
        run("hold", 2 * DW + 1, 4, 1'b0, -1, -1);

        // Stray start while busy, then reset mid-SET with err set.
        q_stuck = 1'b1;
        run("abort", -1, 0, 1'b1, 2 * DW + 1, 1);
        start = 1'b0;
        rst = 1'b1;
        #1;
        check_state("rst_mid", 0, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        q_stuck = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_state("post_rst", 0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
